// File: rtl/seg_scan_mux.sv
// Self-scanning multiplexed display driver: one-hot anode strobe, per-slot blanking and
// double-buffered digits. All outputs are registered and change on the edge the scan FSM moves.
module seg_scan_mux #(
  parameter int NUM_DIGITS       = 4,
  parameter int DIGIT_W          = 4,
  parameter int PRESCALE         = 1024,
  parameter int BLANK_CYCLES     = 16,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic                          lz_suppress,
  output logic [DIGIT_W-1:0]            digit,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic                          frame_done
);

  localparam int PW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                        state;
  logic [PW-1:0]                 ptr;
  logic [PW-1:0]                 ptr_inc;
  logic [CW-1:0]                 cnt;
  logic [NUM_DIGITS*DIGIT_W-1:0] shadow;
  logic [NUM_DIGITS*DIGIT_W-1:0] active;
  logic [NUM_DIGITS*DIGIT_W-1:0] active_nxt;
  logic                          pending;
  logic                          wrap;
  logic                          commit;
  logic [NUM_DIGITS-1:0]         lit_anode [NUM_DIGITS];
  logic [DIGIT_W-1:0]            lit_code  [NUM_DIGITS];

  assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
  assign wrap    = (state == SHOW) && enable && (cnt == SHOW_LAST) && (ptr == PTR_LAST);
  assign commit  = (state == IDLE) || wrap;

  // The displayed image is taken from the post-commit value so a new frame starts clean.
  always_comb begin
    active_nxt = active;
    if (commit && load) begin
      active_nxt = digits_in;
    end else if (commit && pending) begin
      active_nxt = shadow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      active <= active_nxt;
      if (load) begin
        shadow <= digits_in;
      end
      if (commit) begin
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // zero_run stays set while every digit from the top down to i is zero.
  always_comb begin
    logic zero_run;
    logic dark;
    zero_run = 1'b1;
    dark     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (active_nxt[i*DIGIT_W +: DIGIT_W] == '0);
      dark         = blank_mask[i] | (lz_suppress & zero_run & (i != 0));
      lit_anode[i] = dark ? ANODE_OFF : ANODE_OFF ^ (NUM_DIGITS'(1) << i);
      lit_code[i]  = dark ? {DIGIT_W{1'b1}} : active_nxt[i*DIGIT_W +: DIGIT_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      digit      <= '1;
      anode      <= ANODE_OFF;
      frame_done <= 1'b0;
    end else begin
      digit      <= '1;
      anode      <= ANODE_OFF;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          ptr <= '0;
          cnt <= '0;
          if (enable) begin
            if (BLANK_CYCLES == 0) begin
              state <= SHOW;
              digit <= lit_code[0];
              anode <= lit_anode[0];
            end else begin
              state <= BLANK;
            end
          end
        end
        BLANK: begin
          if (!enable) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
          end else if (cnt == BLANK_LAST) begin
            state <= SHOW;
            cnt   <= '0;
            digit <= lit_code[ptr];
            anode <= lit_anode[ptr];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHOW: begin
          if (!enable) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
          end else if (cnt == SHOW_LAST) begin
            cnt        <= '0;
            ptr        <= ptr_inc;
            frame_done <= (ptr == PTR_LAST);
            if (BLANK_CYCLES == 0) begin
              digit <= lit_code[ptr_inc];
              anode <= lit_anode[ptr_inc];
            end else begin
              state <= BLANK;
            end
          end else begin
            cnt   <= cnt + CW'(1);
            digit <= lit_code[ptr];
            anode <= lit_anode[ptr];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed scenarios plus random traffic against a slot-arithmetic model.
module tb_seg_scan_mux;

  localparam int N     = 4;
  localparam int W     = 4;
  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = N * P;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          load;
  logic [15:0]   digits_in;
  logic [3:0]    blank_mask;
  logic          lz_suppress;
  logic [3:0]    digit;
  logic [3:0]    anode;
  logic          frame_done;

  logic          en0;
  logic          load0;
  logic [15:0]   din0;
  logic [3:0]    mask0;
  logic          lz0;
  logic [3:0]    digit0;
  logic [3:0]    anode0;
  logic          frame_done0;

  int            total  = 0;
  int            passed = 0;
  int            fails  = 0;

  // Model state: running flag, cycles since the enable edge, and the buffer contents.
  bit            m_run;
  int            m_t;
  logic [15:0]   m_act;
  logic [15:0]   m_sh;
  bit            m_pend;

  int            s0;
  logic [3:0]    e_an;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS(N), .DIGIT_W(W), .PRESCALE(P), .BLANK_CYCLES(B), .ANODE_ACTIVE_LOW(1)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in),
    .blank_mask(blank_mask), .lz_suppress(lz_suppress),
    .digit(digit), .anode(anode), .frame_done(frame_done)
  );

  seg_scan_mux #(
    .NUM_DIGITS(N), .DIGIT_W(W), .PRESCALE(P), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1)
  ) u_dut_nb (
    .clk(clk), .rst(rst), .enable(en0), .load(load0), .digits_in(din0),
    .blank_mask(mask0), .lz_suppress(lz0),
    .digit(digit0), .anode(anode0), .frame_done(frame_done0)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_t    = 0;
    m_act  = '0;
    m_sh   = '0;
    m_pend = 1'b0;
  endtask

  // One clock: capture inputs seen at the edge, advance the model, then check outputs.
  task automatic step();
    logic        en_s, ld_s, lz_s;
    logic [15:0] din_s;
    logic [3:0]  mask_s;
    bit          wrap, commit;
    int          slot, pos;
    logic [3:0]  ea, ed;
    logic        efd;
    en_s = enable; ld_s = load; din_s = digits_in; mask_s = blank_mask; lz_s = lz_suppress;
    @(posedge clk);
    wrap   = m_run && en_s && ((m_t + 1) % FRAME == 0);
    commit = !m_run || wrap;
    if (!m_run) begin
      if (en_s) begin
        m_run = 1'b1;
        m_t   = 0;
      end
    end else if (!en_s) begin
      m_run = 1'b0;
    end else begin
      m_t++;
    end
    if (commit) begin
      if (ld_s) m_act = din_s;
      else if (m_pend) m_act = m_sh;
      m_pend = 1'b0;
    end else if (ld_s) begin
      m_pend = 1'b1;
    end
    if (ld_s) m_sh = din_s;
    ea = 4'hF; ed = 4'hF; efd = 1'b0;
    if (m_run) begin
      slot = (m_t / P) % N;
      pos  = m_t % P;
      if (pos >= B && !mask_s[slot] && !(lz_s && slot != 0 && (m_act >> (4 * slot)) == 0)) begin
        ea = ~(4'b0001 << slot);
        ed = m_act[4*slot +: 4];
      end
      efd = (m_t > 0) && (m_t % FRAME == 0);
    end
    #1;
    chk("anode", anode, ea);
    chk("digit", digit, ed);
    chk("frame_done", frame_done, efd);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int ph);
    for (int i = 0; i < 2 * FRAME && !(m_run && (m_t % FRAME) == ph); i++) step();
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      r[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; digits_in = '0; blank_mask = '0; lz_suppress = 1'b0;
    en0 = 1'b0; load0 = 1'b0; din0 = '0; mask0 = '0; lz0 = 1'b0;
    model_reset();
    #1;
    chk("rst_anode", anode, 4'hF);
    chk("rst_digit", digit, 4'hF);
    chk("rst_frame_done", frame_done, 1'b0);
    #1 rst = 1'b0;

    // Basic scan of 0x1234: load while idle, then two full frames.
    digits_in = 16'h1234; load = 1'b1; step(); load = 1'b0;
    enable = 1'b1;
    run(2 * FRAME);

    // Load during digit 1: current frame keeps the old value.
    run_until(10);
    digits_in = 16'h5678; load = 1'b1; step(); load = 1'b0;
    run(2 * FRAME);

    // Leading-zero suppression, including an all-zero value.
    lz_suppress = 1'b1;
    digits_in = 16'h0040; load = 1'b1; step(); load = 1'b0;
    run(2 * FRAME);
    digits_in = 16'h0000; load = 1'b1; step(); load = 1'b0;
    run(2 * FRAME);
    lz_suppress = 1'b0;

    // Per-digit blank mask.
    blank_mask = 4'b0100;
    digits_in = 16'h1234; load = 1'b1; step(); load = 1'b0;
    run(2 * FRAME);
    blank_mask = 4'b0000;

    // Drop enable during digit 2 SHOW, re-raise 5 cycles later.
    run_until(20);
    enable = 1'b0;
    run(5);
    enable = 1'b1;
    run(FRAME + 8);

    // Load on the exact wrap edge is shown in the very next frame.
    run_until(FRAME - 1);
    digits_in = 16'h9ABC; load = 1'b1; step(); load = 1'b0;
    run(FRAME + 4);

    // Asynchronous reset mid-SHOW, observed before any clock edge.
    run_until(12);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_anode", anode, 4'hF);
    chk("async_rst_digit", digit, 4'hF);
    chk("async_rst_frame_done", frame_done, 1'b0);
    model_reset();
    #2 rst = 1'b0;
    run(FRAME + 4);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 15) == 0);
      if (load) digits_in = rand_val();
      if ($urandom_range(0, 31) == 0)
        blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 31) == 0) lz_suppress = ~lz_suppress;
      if (enable) begin
        if ($urandom_range(0, 99) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        enable = 1'b1;
      end
      step();
    end
    load = 1'b0; enable = 1'b0;
    run(2);

    // Zero-blanking instance: every slot lit for its full length, no dark gap.
    din0 = 16'h8A35; load0 = 1'b1;
    @(posedge clk); #1;
    load0 = 1'b0; en0 = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 70; t++) begin
      s0   = (t / P) % N;
      e_an = ~(4'b0001 << s0);
      chk("nb_anode", anode0, e_an);
      chk("nb_digit", digit0, din0[4*s0 +: 4]);
      chk("nb_frame_done", frame_done0, (t > 0 && t % FRAME == 0));
      chk("nb_never_dark", anode0 != 4'hF, 1'b1);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
